pc_unit: RTL

//  Program-counter register for the fetch stage. It drives the current PC to the

---
 rtl/pc_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage.
// Sequences IDLE -> RUN -> HALT. In RUN the PC advances to the externally
// incremented value or to a branch target, holds on a stall, and freezes on a halt.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 leave IDLE and begin fetching
//   stall                 hold PC, npc_out and fetch_cnt this cycle
//   branch_taken/tgt      load branch_tgt instead of pc_plus1
//   halt_req              stop fetching; HALT is left only by reset
//   pc_plus1              incremented PC returned from the external incrementer
//   pc_out                current PC (incrementer input and instr-mem address)
//   npc_out               registered pc_plus1 of the fetched instruction, for IF/ID
//   fetch_valid, halted   status of the current cycle
//   fetch_cnt             number of PC advances, wraps silently
module pc_unit #(
  parameter int unsigned   W          = 32,
  parameter logic [W-1:0]  RESET_ADDR = '0,
  parameter int unsigned   CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [W-1:0]     branch_tgt,
  input  logic             halt_req,
  input  logic [W-1:0]     pc_plus1,
  output logic [W-1:0]     pc_out,
  output logic [W-1:0]     npc_out,
  output logic             fetch_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             advance;
  logic [W-1:0]     pc_nxt;
  logic [W-1:0]     npc_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; halt_req outranks everything else in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (halt_req) state_nxt = S_HALT;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs. A branch seen during a stall is
  // dropped here on purpose: the driver holds it until the stall clears.
  always_comb begin
    advance = (state == S_RUN) && !halt_req && !stall;
    pc_nxt  = pc_out;
    npc_nxt = npc_out;
    cnt_nxt = fetch_cnt;
    if (advance) begin
      pc_nxt  = branch_taken ? branch_tgt : pc_plus1;
      npc_nxt = pc_plus1;
      cnt_nxt = fetch_cnt + CNT_W'(1);
    end
  end

  // Output registers; status flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out      <= RESET_ADDR;
      npc_out     <= '0;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      pc_out      <= pc_nxt;
      npc_out     <= npc_nxt;
      fetch_valid <= (state_nxt == S_RUN);
      halted      <= (state_nxt == S_HALT);
      fetch_cnt   <= cnt_nxt;
    end
  end

endmodule
